multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum consecutive mem_req cycles without mem_ready before bus error.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 instr  input  32  instruction register contents (valid from DECODE onward).
REQ-005 alu_zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completes the current request this cycle.
REQ-007 mem_req  output  1  memory request; mem_we  output  1  write strobe; mem_addr_sel  output  1  (0=PC, 1=ALU result).
REQ-008 ir_we  output  1  IR and old_pc load enable.
REQ-009 pc_we  output  1  PC write; pc_src  output  2  (00=PC+4, 01=old_pc+B-immediate).
REQ-010 alu_src_b  output  2  (00=rs2, 01=immediate); alu_op  output  2  (00=add, 01=sub, 10=funct-decoded).
REQ-011 reg_we  output  1  register write; wb_sel  output  1  (0=ALU, 1=memory).
REQ-012 illegal  output  1  sticky illegal opcode; bus_err  output  1  sticky memory timeout; state  output  3  debug state code.

Function
REQ-013 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-014 Supported opcodes SHALL be R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011 and BRANCH 1100011 (beq).
REQ-015 FETCH: mem_req=1, mem_addr_sel=0, mem_we=0; on mem_ready, ir_we=1, pc_we=1, pc_src=00 in the same cycle, then DECODE.
REQ-016 DECODE: one cycle, no strobes; supported opcode -> EXEC; any other -> HALT with illegal set.
REQ-017 EXEC, R: alu_src_b=00, alu_op=10 -> WB.
REQ-018 EXEC, I-ALU: alu_src_b=01, alu_op=10 -> WB.
REQ-019 EXEC, LOAD/STORE: alu_src_b=01, alu_op=00 -> MEM.
REQ-020 EXEC, BRANCH: alu_src_b=00, alu_op=01, pc_src=01, pc_we=alu_zero -> FETCH.
REQ-021 MEM: mem_req=1, mem_addr_sel=1, mem_we=1 only for STORE; on mem_ready, LOAD -> WB and STORE -> FETCH.
REQ-022 WB: reg_we=1 for exactly one cycle, wb_sel=1 for LOAD and 0 otherwise -> FETCH.
REQ-023 Handshake: mem_req, mem_we and mem_addr_sel SHALL hold stable from assertion until the mem_ready cycle inclusive; mem_req SHALL drop the cycle after mem_ready.
REQ-024 The wait counter SHALL clear on entry to FETCH or MEM and increment each mem_req cycle without mem_ready.
REQ-025 When the counter reaches MAX_WAIT, the next state SHALL be HALT and bus_err SHALL be set.
REQ-026 mem_ready in the same cycle the counter reaches MAX_WAIT SHALL take priority and complete normally.
REQ-027 HALT: all strobes 0; HALT SHALL be left only by rst.
REQ-028 Latency with zero-wait memory: R/I-ALU 4 cycles, LOAD 5, STORE 4, BRANCH 3.
REQ-029 Strobes not listed for a state SHALL be 0; mem_ready outside FETCH/MEM SHALL be ignored.
REQ-030 The state output SHALL encode FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.

Reset
REQ-031 rst SHALL force the FETCH state, clear the counter, illegal and bus_err, and drive all strobes 0 in the following cycle, from any state including mid-MEM.
REQ-032 rst SHALL override mem_ready and timeout in the same cycle.

Structure
REQ-033 Opcode constants, the state enum, and the alu_op/pc_src/alu_src_b encodings SHALL live in the shared package cpu_pkg.
REQ-034 The wait counter SHALL be the sub-module mem_wait_timer (inputs: clear, count; output: expired).
REQ-035 State SHALL be registered; outputs SHALL be combinational from state, opcode, mem_ready and alu_zero.

Verification
REQ-036 add 0x003100B3, mem_ready=1 -> states 0,1,2,4; pc_we in cycle 1; reg_we=1, wb_sel=0 in cycle 4 only.
REQ-037 ld 0x0082B303, mem_ready delayed 3 cycles in MEM -> mem_req=1, mem_addr_sel=1, mem_we=0 for 4 cycles; then one WB cycle with wb_sel=1.
REQ-038 sd 0x0062B423 -> mem_we=1 in MEM, no reg_we, returns to FETCH.
REQ-039 beq 0x00628463: alu_zero=1 -> pc_we=1, pc_src=01 in EXEC; alu_zero=0 -> pc_we=0 in EXEC.
REQ-040 0xFFFFFFFF -> HALT, illegal=1 held 20 cycles; mem_ready never in FETCH -> HALT, bus_err=1 after 15 wait cycles.
REQ-041 rst during MEM of a store -> mem_req=0, mem_we=0, state=0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM state codes
// and the datapath mux/ALU select values.
package cpu_pkg;

  localparam int DEFAULT_MAX_WAIT = 15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Codes are visible on the debug state port, so they are fixed explicitly.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01
  } pc_src_e;

  typedef enum logic [1:0] {
    ALU_B_RS2 = 2'b00,
    ALU_B_IMM = 2'b01
  } alu_src_b_e;

  localparam logic ADDR_SEL_PC  = 1'b0;
  localparam logic ADDR_SEL_ALU = 1'b1;

  function automatic logic is_supported(input logic [6:0] op);
    logic ok;
    case (op)
      OP_R, OP_I_ALU, OP_LOAD, OP_STORE, OP_BRANCH: ok = 1'b1;
      default:                                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request/ready handshake between the controller and the memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-request cycles that did not complete. Saturates
// at MAX_WAIT; expired is a pure function of the register so it never forms
// a combinational path back through the FSM's count request.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expired = (count_q == LIMIT);

  // Next count: clear wins, otherwise step while waiting and not saturated.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register; reset reaches it through clear.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV-style datapath.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   FETCH  | request instruction at PC; on ready load IR, PC <= PC+4
//   DECODE | one idle cycle while the IR settles; reject bad opcodes
//   EXEC   | drive ALU selects; branches resolve here
//   MEM    | data access at ALU result; load -> WB, store -> FETCH
//   WB     | single-cycle register write (ALU or memory data)
//   HALT   | illegal opcode or bus timeout; only rst leaves
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              instr,
  input  logic                     alu_zero,
  multicycle_ctrl_if.master        mem,
  output logic                     ir_we,
  output logic                     pc_we,
  output logic [1:0]               pc_src,
  output logic [1:0]               alu_src_b,
  output logic [1:0]               alu_op,
  output logic                     reg_we,
  output logic                     wb_sel,
  output logic                     illegal,
  output logic                     bus_err,
  output logic [2:0]               state
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;

  logic [6:0] opcode;
  logic       unused_instr_hi;

  logic       tmr_clear;
  logic       tmr_count;
  logic       tmr_expired;

  logic       mem_req_c, mem_we_c, mem_addr_sel_c;
  logic       ir_we_c, pc_we_c, reg_we_c, wb_sel_c;
  logic [1:0] pc_src_c, alu_src_b_c, alu_op_c;

  assign opcode          = instr[6:0];
  assign unused_instr_hi = ^instr[31:7];

  // Clearing on every state change covers entry into FETCH and MEM; the
  // counter is only advanced from those two states.
  assign tmr_clear = rst || (state_d != state_q);

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .clear   (tmr_clear),
    .count   (tmr_count),
    .expired (tmr_expired)
  );

  // Next-state, sticky flag updates and per-state strobes.
  always_comb begin
    state_d        = state_q;
    illegal_d      = illegal_q;
    bus_err_d      = bus_err_q;
    tmr_count      = 1'b0;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = ADDR_SEL_PC;
    ir_we_c        = 1'b0;
    pc_we_c        = 1'b0;
    pc_src_c       = PC_SRC_SEQ;
    alu_src_b_c    = ALU_B_RS2;
    alu_op_c       = ALU_ADD;
    reg_we_c       = 1'b0;
    wb_sel_c       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = ADDR_SEL_PC;
        tmr_count      = !mem.mem_ready;
        // A ready arriving on the expiry cycle still completes normally.
        if (mem.mem_ready) begin
          ir_we_c  = 1'b1;
          pc_we_c  = 1'b1;
          pc_src_c = PC_SRC_SEQ;
          state_d  = ST_DECODE;
        end else if (tmr_expired) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end
      end

      ST_DECODE: begin
        if (is_supported(opcode)) begin
          state_d = ST_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end
      end

      ST_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_src_b_c = ALU_B_RS2;
            alu_op_c    = ALU_FUNCT;
            state_d     = ST_WB;
          end
          OP_I_ALU: begin
            alu_src_b_c = ALU_B_IMM;
            alu_op_c    = ALU_FUNCT;
            state_d     = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b_c = ALU_B_IMM;
            alu_op_c    = ALU_ADD;
            state_d     = ST_MEM;
          end
          OP_BRANCH: begin
            alu_src_b_c = ALU_B_RS2;
            alu_op_c    = ALU_SUB;
            pc_src_c    = PC_SRC_BRANCH;
            pc_we_c     = alu_zero;
            state_d     = ST_FETCH;
          end
          default: begin
            // IR changed under us after DECODE; treat as illegal.
            illegal_d = 1'b1;
            state_d   = ST_HALT;
          end
        endcase
      end

      ST_MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = ADDR_SEL_ALU;
        mem_we_c       = (opcode == OP_STORE);
        tmr_count      = !mem.mem_ready;
        if (mem.mem_ready) begin
          state_d = (opcode == OP_LOAD) ? ST_WB : ST_FETCH;
        end else if (tmr_expired) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end
      end

      ST_WB: begin
        reg_we_c = 1'b1;
        wb_sel_c = (opcode == OP_LOAD);
        state_d  = ST_FETCH;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // State and sticky error flags; rst beats ready and timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Strobes are held quiet while rst is asserted so an aborted access
  // (e.g. a store in MEM) is withdrawn immediately.
  assign mem.mem_req      = mem_req_c & ~rst;
  assign mem.mem_we       = mem_we_c & ~rst;
  assign mem.mem_addr_sel = mem_addr_sel_c & ~rst;
  assign ir_we            = ir_we_c & ~rst;
  assign pc_we            = pc_we_c & ~rst;
  assign pc_src           = rst ? 2'b00 : pc_src_c;
  assign alu_src_b        = rst ? 2'b00 : alu_src_b_c;
  assign alu_op           = rst ? 2'b00 : alu_op_c;
  assign reg_we           = reg_we_c & ~rst;
  assign wb_sel           = wb_sel_c & ~rst;

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction cycle tables of
// expected state and strobes, plus timeout, illegal and reset scenarios.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        alu_zero;
  logic        mem_ready;
  logic        ir_we, pc_we, reg_we, wb_sel, illegal, bus_err;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [2:0]  state;
  logic [15:0] obs;

  int checks   = 0;
  int failures = 0;

  multicycle_ctrl_if bus ();
  assign bus.mem_ready = mem_ready;

  multicycle_ctrl #(.MAX_WAIT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .alu_zero  (alu_zero),
    .mem       (bus),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .illegal   (illegal),
    .bus_err   (bus_err),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src_b, alu_op, reg_we, wb_sel}
  assign obs = {state, bus.mem_req, bus.mem_we, bus.mem_addr_sel, ir_we, pc_we,
                pc_src, alu_src_b, alu_op, reg_we, wb_sel};

  function automatic logic [15:0] ev(input int st, input int req, input int we, input int asel,
                                     input int irwe, input int pcwe, input int psrc,
                                     input int ab, input int aop, input int rwe, input int wbs);
    return {st[2:0], req[0], we[0], asel[0], irwe[0], pcwe[0], psrc[1:0], ab[1:0], aop[1:0],
            rwe[0], wbs[0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b0; alu_zero = 1'b0; instr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== ev(0,0,0,0,0,0,0,0,0,0,0)) begin
      failures++; $display("FAIL reset_outputs: got %h expected %h", obs, ev(0,0,0,0,0,0,0,0,0,0,0));
    end
    checks++;
    if (illegal !== 1'b0 || bus_err !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got illegal=%b bus_err=%b expected 0 0", illegal, bus_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== ev(0,1,0,0,0,0,0,0,0,0,0)) begin
      failures++; $display("FAIL reset_release_fetch: got %h expected %h", obs, ev(0,1,0,0,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_add();
    logic [15:0] exp_v [5];
    bit          rdy [5];
    exp_v = '{ev(0,1,0,0,1,1,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0), ev(2,0,0,0,0,0,0,0,2,0,0),
              ev(4,0,0,0,0,0,0,0,0,1,0), ev(0,1,0,0,0,0,0,0,0,0,0)};
    rdy   = '{1, 1, 1, 1, 0};
    instr = 32'h003100B3;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        failures++; $display("FAIL add row%0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_ialu();
    logic [15:0] exp_v [5];
    bit          rdy [5];
    exp_v = '{ev(0,1,0,0,1,1,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0), ev(2,0,0,0,0,0,0,1,2,0,0),
              ev(4,0,0,0,0,0,0,0,0,1,0), ev(0,1,0,0,0,0,0,0,0,0,0)};
    rdy   = '{1, 0, 1, 0, 0};
    instr = 32'h00500093;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        failures++; $display("FAIL ialu row%0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_load();
    logic [15:0] exp_v [9];
    bit          rdy [9];
    exp_v = '{ev(0,1,0,0,1,1,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0), ev(2,0,0,0,0,0,0,1,0,0,0),
              ev(3,1,0,1,0,0,0,0,0,0,0), ev(3,1,0,1,0,0,0,0,0,0,0), ev(3,1,0,1,0,0,0,0,0,0,0),
              ev(3,1,0,1,0,0,0,0,0,0,0), ev(4,0,0,0,0,0,0,0,0,1,1), ev(0,1,0,0,0,0,0,0,0,0,0)};
    rdy   = '{1, 1, 1, 0, 0, 0, 1, 1, 0};
    instr = 32'h0082B303;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        failures++; $display("FAIL load row%0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (i < 8) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_store();
    logic [15:0] exp_v [6];
    bit          rdy [6];
    exp_v = '{ev(0,1,0,0,1,1,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0), ev(2,0,0,0,0,0,0,1,0,0,0),
              ev(3,1,1,1,0,0,0,0,0,0,0), ev(3,1,1,1,0,0,0,0,0,0,0), ev(0,1,0,0,0,0,0,0,0,0,0)};
    rdy   = '{1, 1, 0, 0, 1, 0};
    instr = 32'h0062B423;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        failures++; $display("FAIL store row%0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (i < 5) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_branch();
    logic [15:0] exp_v [7];
    bit          rdy [7];
    bit          zf [7];
    exp_v = '{ev(0,1,0,0,1,1,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0), ev(2,0,0,0,0,1,1,0,1,0,0),
              ev(0,1,0,0,1,1,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0), ev(2,0,0,0,0,0,1,0,1,0,0),
              ev(0,1,0,0,0,0,0,0,0,0,0)};
    rdy   = '{1, 0, 1, 1, 0, 0, 0};
    zf    = '{1, 0, 1, 1, 1, 0, 1};
    instr = 32'h00628463;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      alu_zero  = zf[i];
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        failures++; $display("FAIL beq row%0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (i < 6) begin @(posedge clk); #1; end
    end
    alu_zero = 1'b0;
  endtask

  // Ready on the cycle the counter reaches 15 must still complete the fetch.
  task automatic test_wait_priority();
    logic [15:0] exp_row;
    instr = 32'h003100B3;
    for (int i = 0; i < 16; i++) begin
      mem_ready = (i == 15);
      exp_row   = (i == 15) ? ev(0,1,0,0,1,1,0,0,0,0,0) : ev(0,1,0,0,0,0,0,0,0,0,0);
      #1;
      checks++;
      if (obs !== exp_row) begin
        failures++; $display("FAIL wait_prio row%0d: got %h expected %h", i, obs, exp_row);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    checks++;
    if (state !== 3'd1 || bus_err !== 1'b0) begin
      failures++; $display("FAIL wait_prio_decode: got state=%0d bus_err=%b expected 1 0", state, bus_err);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== ev(0,1,0,0,0,0,0,0,0,0,0)) begin
      failures++; $display("FAIL wait_prio_refetch: got %h expected %h", obs, ev(0,1,0,0,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_bus_err();
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (obs !== ev(0,1,0,0,0,0,0,0,0,0,0) || bus_err !== 1'b0) begin
        failures++; $display("FAIL bus_err_wait row%0d: got %h bus_err=%b expected %h 0",
                             i, obs, bus_err, ev(0,1,0,0,0,0,0,0,0,0,0));
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      #1;
      checks++;
      if (obs !== ev(7,0,0,0,0,0,0,0,0,0,0) || bus_err !== 1'b1 || illegal !== 1'b0) begin
        failures++; $display("FAIL bus_err_halt row%0d: got %h bus_err=%b illegal=%b expected %h 1 0",
                             i, obs, bus_err, illegal, ev(7,0,0,0,0,0,0,0,0,0,0));
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_illegal();
    instr = 32'hFFFFFFFF;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== ev(0,1,0,0,1,1,0,0,0,0,0)) begin
      failures++; $display("FAIL illegal_fetch: got %h expected %h", obs, ev(0,1,0,0,1,1,0,0,0,0,0));
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== ev(1,0,0,0,0,0,0,0,0,0,0) || illegal !== 1'b0) begin
      failures++; $display("FAIL illegal_decode: got %h illegal=%b expected %h 0",
                           obs, illegal, ev(1,0,0,0,0,0,0,0,0,0,0));
    end
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      alu_zero  = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (obs !== ev(7,0,0,0,0,0,0,0,0,0,0) || illegal !== 1'b1 || bus_err !== 1'b0) begin
        failures++; $display("FAIL illegal_hold cyc%0d: got %h illegal=%b bus_err=%b expected %h 1 0",
                             i, obs, illegal, bus_err, ev(7,0,0,0,0,0,0,0,0,0,0));
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    alu_zero  = 1'b0;
  endtask

  task automatic test_rst_mid_mem();
    instr = 32'h0062B423;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; mem_ready = 1'b0; end
    #1;
    checks++;
    if (obs !== ev(3,1,1,1,0,0,0,0,0,0,0)) begin
      failures++; $display("FAIL rst_mem_pre: got %h expected %h", obs, ev(3,1,1,1,0,0,0,0,0,0,0));
    end
    rst = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd0 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
      failures++; $display("FAIL rst_mem_next: got state=%0d mem_req=%b mem_we=%b expected 0 0 0",
                           state, bus.mem_req, bus.mem_we);
    end
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== ev(0,1,0,0,0,0,0,0,0,0,0)) begin
      failures++; $display("FAIL rst_mem_refetch: got %h expected %h", obs, ev(0,1,0,0,0,0,0,0,0,0,0));
    end
  endtask

  // rst on the expiry cycle must win over the pending bus error.
  task automatic test_rst_over_timeout();
    mem_ready = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd0 || bus_err !== 1'b0) begin
      failures++; $display("FAIL rst_timeout: got state=%0d bus_err=%b expected 0 0", state, bus_err);
    end
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (obs !== ev(0,1,0,0,0,0,0,0,0,0,0) || bus_err !== 1'b0) begin
      failures++; $display("FAIL rst_timeout_cleared: got %h bus_err=%b expected %h 0",
                           obs, bus_err, ev(0,1,0,0,0,0,0,0,0,0,0));
    end
  endtask

  initial begin
    rst = 1'b1; instr = 32'h0; alu_zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_add();
    test_ialu();
    test_load();
    test_store();
    test_branch();
    test_wait_priority();
    test_bus_err();
    test_reset();
    test_illegal();
    test_reset();
    test_rst_mid_mem();
    test_rst_over_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
